// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential barrel shifter: datapath sizing,
// shift-direction codes and the controller state encoding.
package shifter_pkg;

    localparam int SHIFT_DATA_W = 32;
    localparam int SHIFT_AMT_W  = $clog2(SHIFT_DATA_W);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance shifter stage: logical left or arithmetic right by AMT
// when enabled, otherwise a straight pass-through.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int AMT    = 1
) (
    input  logic              i_en,
    input  logic              i_dir,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    // Right shifts replicate the current MSB so repeated stages stay arithmetic.
    always_comb begin
        o_q = i_d;
        if (i_en) begin
            case (i_dir)
                DIR_RIGHT: o_q = {{AMT{i_d[DATA_W-1]}}, i_d[DATA_W-1:AMT]};
                DIR_LEFT:  o_q = {i_d[DATA_W-1-AMT:0], {AMT{1'b0}}};
                default:   o_q = i_d;
            endcase
        end
    end

endmodule

// File: rtl/seq_barrel_shifter_32.sv
// Multi-cycle barrel shifter: applies one power-of-two stage per clock,
// walking the shift amount from its MSB down to bit 0.
module seq_barrel_shifter_32
    import shifter_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_sh_dir,
    input  logic [AMT_W-1:0]  i_sh_amt,
    input  logic [DATA_W-1:0] i_d_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_d_out,
    output logic              o_busy
);

    localparam int K_W = $clog2(AMT_W);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [DATA_W-1:0]            r_work;
    logic [AMT_W-1:0]             r_amt;
    logic                         r_dir;
    logic [K_W-1:0]               r_k;
    logic [AMT_W-1:0][DATA_W-1:0] w_stage_q;

    // Stage gi shifts by 2^gi; only the one selected by r_k is used each cycle.
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
        shift_stage #(
            .DATA_W (DATA_W),
            .AMT    (1 << gi)
        ) u_stage (
            .i_en  (r_amt[gi]),
            .i_dir (r_dir),
            .i_d   (r_work),
            .o_q   (w_stage_q[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_next_state = SHIFT;
            end
            SHIFT: begin
                o_busy = 1'b1;
                if (r_k == '0) w_next_state = DONE;
            end
            DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operands are captured only on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_amt  <= '0;
            r_dir  <= 1'b0;
            r_k    <= K_W'(AMT_W - 1);
        end else if (r_state == IDLE && i_in_valid) begin
            r_work <= i_d_in;
            r_amt  <= i_sh_amt;
            r_dir  <= i_sh_dir;
            r_k    <= K_W'(AMT_W - 1);
        end else if (r_state == SHIFT) begin
            r_work <= w_stage_q[r_k];
            if (r_k != '0) r_k <= r_k - 1'b1;
        end
    end

    assign o_d_out = r_work;

endmodule

// File: tb/tb_seq_barrel_shifter_32.sv
// Directed self-checking bench for seq_barrel_shifter_32: hand-computed shift
// vectors, latency, backpressure, busy-time input rejection and mid-shift reset.
module tb_seq_barrel_shifter_32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic        shDir = 1'b0;
   logic [4:0]  shAmt = 5'd0;
   logic [31:0] dIn = 32'd0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] dOut;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic        vecDir [13];
   logic [4:0]  vecAmt [13];
   logic [31:0] vecData [13];
   logic [31:0] vecExp [13];

   seq_barrel_shifter_32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (inValid),
      .o_in_ready  (inReady),
      .i_sh_dir    (shDir),
      .i_sh_amt    (shAmt),
      .i_d_in      (dIn),
      .o_out_valid (outValid),
      .i_out_ready (outReady),
      .o_d_out     (dOut),
      .o_busy      (busy)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issues one request, scrambles inputs after the accept edge, and waits
   // (bounded) for the result; latency counts the accepting edge as edge 1
   task automatic applyStimulus(input logic dir, input logic [4:0] amt, input logic [31:0] d,
                                output logic [31:0] result, output int latency);
      @(negedge clk);
      outReady = 1'b0;
      inValid  = 1'b1;
      shDir    = dir;
      shAmt    = amt;
      dIn      = d;
      @(posedge clk);
      latency = 1;
      #1;
      inValid = 1'b0;
      shDir   = ~dir;
      shAmt   = ~amt;
      dIn     = ~d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (outValid) break;
         @(posedge clk);
         latency++;
      end
      result = dOut;
   endtask

   // Hands the result to the consumer and confirms the block is free again
   task automatic releaseResult(input string tag);
      @(negedge clk);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      @(negedge clk);
      checkOutput({tag, " outValid after release"}, 32'(outValid), 32'd0);
      checkOutput({tag, " inReady after release"}, 32'(inReady), 32'd1);
      checkOutput({tag, " busy after release"}, 32'(busy), 32'd0);
   endtask

   // Linear directed sequence
   initial begin
      logic [31:0] result;
      logic [31:0] held;
      int latency;

      vecDir[0]  = 1'b1; vecAmt[0]  = 5'd16; vecData[0]  = 32'h80000000; vecExp[0]  = 32'hFFFF8000;
      vecDir[1]  = 1'b0; vecAmt[1]  = 5'd4;  vecData[1]  = 32'h00001234; vecExp[1]  = 32'h00012340;
      vecDir[2]  = 1'b0; vecAmt[2]  = 5'd31; vecData[2]  = 32'h00000003; vecExp[2]  = 32'h80000000;
      vecDir[3]  = 1'b1; vecAmt[3]  = 5'd31; vecData[3]  = 32'h7FFFFFFF; vecExp[3]  = 32'h00000000;
      vecDir[4]  = 1'b1; vecAmt[4]  = 5'd31; vecData[4]  = 32'h80000001; vecExp[4]  = 32'hFFFFFFFF;
      vecDir[5]  = 1'b0; vecAmt[5]  = 5'd0;  vecData[5]  = 32'hDEADBEEF; vecExp[5]  = 32'hDEADBEEF;
      vecDir[6]  = 1'b1; vecAmt[6]  = 5'd0;  vecData[6]  = 32'hDEADBEEF; vecExp[6]  = 32'hDEADBEEF;
      vecDir[7]  = 1'b1; vecAmt[7]  = 5'd4;  vecData[7]  = 32'h12345678; vecExp[7]  = 32'h01234567;
      vecDir[8]  = 1'b1; vecAmt[8]  = 5'd5;  vecData[8]  = 32'h80000000; vecExp[8]  = 32'hFC000000;
      vecDir[9]  = 1'b0; vecAmt[9]  = 5'd21; vecData[9]  = 32'h00000001; vecExp[9]  = 32'h00200000;
      vecDir[10] = 1'b0; vecAmt[10] = 5'd16; vecData[10] = 32'h0000ABCD; vecExp[10] = 32'hABCD0000;
      vecDir[11] = 1'b1; vecAmt[11] = 5'd8;  vecData[11] = 32'hF0F0F0F0; vecExp[11] = 32'hFFF0F0F0;
      vecDir[12] = 1'b1; vecAmt[12] = 5'd3;  vecData[12] = 32'h00000080; vecExp[12] = 32'h00000010;

      repeat (2) @(negedge clk);
      checkOutput("reset inReady", 32'(inReady), 32'd1);
      checkOutput("reset outValid", 32'(outValid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset dOut", dOut, 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 13; v++) begin
         applyStimulus(vecDir[v], vecAmt[v], vecData[v], result, latency);
         checkOutput($sformatf("vec%0d result", v), result, vecExp[v]);
         checkOutput($sformatf("vec%0d latency", v), 32'(latency), 32'd6);
         releaseResult($sformatf("vec%0d", v));
      end

      $display("[TB] backpressure with ignored requests");
      applyStimulus(1'b1, 5'd16, 32'h80000000, held, latency);
      checkOutput("bp result", held, 32'hFFFF8000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bp%0d dOut", i), dOut, held);
         checkOutput($sformatf("bp%0d outValid", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("bp%0d inReady", i), 32'(inReady), 32'd0);
         inValid = i[0];
         shDir   = 1'b0;
         shAmt   = 5'd1;
         dIn     = 32'h12340000 + 32'(i);
      end
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("bp final dOut", dOut, held);
      releaseResult("bp");

      $display("[TB] reset during third shift cycle");
      @(negedge clk);
      inValid = 1'b1;
      shDir   = 1'b1;
      shAmt   = 5'd16;
      dIn     = 32'h80000000;
      @(posedge clk);
      #1 inValid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset inReady", 32'(inReady), 32'd1);
      checkOutput("midreset outValid", 32'(outValid), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset dOut", dOut, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 5'd8, 32'h000000FF, result, latency);
      checkOutput("postreset result", result, 32'h0000FF00);
      checkOutput("postreset latency", 32'(latency), 32'd6);
      releaseResult("postreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
